// File: rtl/pipe_defs.sv
// rtl/pipe_defs.sv - shared encodings and scoreboard slot type for the pipeline hazard unit
package pipe_defs;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [1:0] WB_MEM = 2'b10;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
  } slot_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_BR_WAIT = 1'b1
  } br_state_e;

  // x0 is hardwired zero, so it can never be a real producer.
  function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] r, input logic re);
    return s.v & s.we & (s.rd == r) & (r != '0) & re;
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// rtl/hazard_slot_pipe.sv - 3-deep EX/MEM/WB destination scoreboard with bubble insert
module hazard_slot_pipe
  import pipe_defs::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  issue,
  input  slot_t id_slot,
  output slot_t ex_slot,
  output slot_t mem_slot,
  output slot_t wb_slot
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      ex_slot  <= issue ? id_slot : '0;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - forward select, load-use stall and branch fetch-hold control for the RV32 pipe
module pipe_hazard_unit
  import pipe_defs::*;
#(
  parameter int FWD_EN          = 1,
  parameter int BR_STALL_CYCLES = 2
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rD1_re,
  input  logic             id_rD2_re,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_we,
  input  logic [1:0]       id_reg_write,
  input  logic             id_branch,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
);

  localparam logic [2:0] BR_CNT_INIT = 3'(BR_STALL_CYCLES - 1);

  slot_t     id_slot, ex_slot, mem_slot, wb_slot;
  logic      issue, data_stall, stall_raw, br_take;
  logic      ma_ex, ma_mem, ma_wb, mb_ex, mb_mem, mb_wb;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  br_state_e state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic      unused_ld;

  assign id_slot = '{v: 1'b1, rd: id_rd, we: id_reg_we, ld: (id_reg_write == WB_MEM)};
  assign issue   = id_valid & ~data_stall;

  hazard_slot_pipe u_slots (
    .clk      (cpu_clk),
    .rst      (cpu_rst),
    .issue    (issue),
    .id_slot  (id_slot),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .wb_slot  (wb_slot)
  );

  // Load flags only matter in EX; older slots already have their data.
  assign unused_ld = &{1'b0, mem_slot.ld, wb_slot.ld};

  assign ma_ex  = slot_match(ex_slot,  id_rs1, id_rD1_re);
  assign ma_mem = slot_match(mem_slot, id_rs1, id_rD1_re);
  assign ma_wb  = slot_match(wb_slot,  id_rs1, id_rD1_re);
  assign mb_ex  = slot_match(ex_slot,  id_rs2, id_rD2_re);
  assign mb_mem = slot_match(mem_slot, id_rs2, id_rD2_re);
  assign mb_wb  = slot_match(wb_slot,  id_rs2, id_rD2_re);

  always_comb begin
    fwd_a_raw = FWD_RF;
    fwd_b_raw = FWD_RF;
    stall_raw = 1'b0;
    if (FWD_EN != 0) begin
      if (ma_ex)       fwd_a_raw = FWD_EX;
      else if (ma_mem) fwd_a_raw = FWD_MEM;
      else if (ma_wb)  fwd_a_raw = FWD_WB;
      if (mb_ex)       fwd_b_raw = FWD_EX;
      else if (mb_mem) fwd_b_raw = FWD_MEM;
      else if (mb_wb)  fwd_b_raw = FWD_WB;
      stall_raw = ex_slot.ld & (ma_ex | mb_ex);
    end else begin
      // RF write happens at the end of WB, so a WB producer is not yet readable.
      stall_raw = ma_ex | ma_mem | ma_wb | mb_ex | mb_mem | mb_wb;
    end
  end

  assign data_stall = id_valid & stall_raw;
  assign br_take    = (state == ST_IDLE) & id_valid & id_branch & ~data_stall;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The issue cycle is the first hold cycle; BR_WAIT covers the remaining ones.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (br_take && (BR_CNT_INIT != 3'd0)) begin
          state_nxt = ST_BR_WAIT;
          cnt_nxt   = BR_CNT_INIT;
        end
      end
      ST_BR_WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt <= 3'd1) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    fwd_a_sel   = FWD_RF;
    fwd_b_sel   = FWD_RF;
    if (!cpu_rst) begin
      stall_pc    = data_stall | br_take | (state == ST_BR_WAIT);
      stall_ifid  = data_stall;
      flush_ifid  = ~data_stall & (br_take | (state == ST_BR_WAIT));
      bubble_idex = data_stall;
      fwd_a_sel   = fwd_a_raw;
      fwd_b_sel   = fwd_b_raw;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed self-checking bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

  logic       cpu_clk = 1'b0;
  logic       cpu_rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rD1_re, id_rD2_re, id_reg_we, id_branch;
  logic [1:0] id_reg_write;

  logic       sp_f, si_f, fl_f, bb_f;
  logic [1:0] fa_f, fb_f;
  logic       sp_n, si_n, fl_n, bb_n;
  logic [1:0] fa_n, fb_n;

  wire [7:0] out_f = {sp_f, si_f, fl_f, bb_f, fa_f, fb_f};
  wire [7:0] out_n = {sp_n, si_n, fl_n, bb_n, fa_n, fb_n};

  int checks = 0;
  int failures = 0;

  always #5 cpu_clk = ~cpu_clk;

  pipe_hazard_unit #(.FWD_EN(1), .BR_STALL_CYCLES(2)) u_fwd (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rD1_re(id_rD1_re), .id_rD2_re(id_rD2_re),
    .id_rd(id_rd), .id_reg_we(id_reg_we), .id_reg_write(id_reg_write), .id_branch(id_branch),
    .stall_pc(sp_f), .stall_ifid(si_f), .flush_ifid(fl_f), .bubble_idex(bb_f),
    .fwd_a_sel(fa_f), .fwd_b_sel(fb_f)
  );

  pipe_hazard_unit #(.FWD_EN(0), .BR_STALL_CYCLES(2)) u_nofwd (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rD1_re(id_rD1_re), .id_rD2_re(id_rD2_re),
    .id_rd(id_rd), .id_reg_we(id_reg_we), .id_reg_write(id_reg_write), .id_branch(id_branch),
    .stall_pc(sp_n), .stall_ifid(si_n), .flush_ifid(fl_n), .bubble_idex(bb_n),
    .fwd_a_sel(fa_n), .fwd_b_sel(fb_n)
  );

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic re1, input logic re2, input logic [4:0] rd,
                       input logic we, input logic [1:0] wr, input logic br);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rD1_re = re1; id_rD2_re = re2;
    id_rd = rd; id_reg_we = we; id_reg_write = wr; id_branch = br;
  endtask

  task automatic nxt();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    nxt();
    cpu_rst = 1'b0;
  endtask

  // Output vector order: {stall_pc, stall_ifid, flush_ifid, bubble_idex, fwd_a[1:0], fwd_b[1:0]}
  task automatic test_reset();
    cpu_rst = 1'b1;
    drive(1, 5'd3, 5'd4, 1, 1, 5'd3, 1, 2'b10, 1);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b0000_0000) begin failures++; $display("FAIL reset_fwd got=%b exp=%b", out_f, 8'b0); end
    checks++; if (out_n !== 8'b0000_0000) begin failures++; $display("FAIL reset_nofwd got=%b exp=%b", out_n, 8'b0); end
    nxt();
    cpu_rst = 1'b0;
    drive(1, 5'd3, 5'd4, 1, 1, 5'd9, 1, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b0000_0000) begin failures++; $display("FAIL reset_empty got=%b exp=%b", out_f, 8'b0); end
    nxt();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b0000_0000) begin failures++; $display("FAIL b2b_first got=%b exp=%b", out_f, 8'b0000_0000); end
    nxt();
    drive(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b0000_0100) begin failures++; $display("FAIL b2b_fwd_ex got=%b exp=%b", out_f, 8'b0000_0100); end
    nxt();
    drive(1, 5'd5, 5'd6, 1, 1, 5'd5, 1, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b0000_1001) begin failures++; $display("FAIL b2b_fwd_mem got=%b exp=%b", out_f, 8'b0000_1001); end
    nxt();
    drive(1, 5'd5, 5'd6, 1, 1, 5'd7, 1, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b0000_0110) begin failures++; $display("FAIL b2b_prio got=%b exp=%b", out_f, 8'b0000_0110); end
    nxt();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 5'd2, 5'd0, 1, 0, 5'd7, 1, 2'b10, 0);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b0000_0000) begin failures++; $display("FAIL lu_load got=%b exp=%b", out_f, 8'b0000_0000); end
    nxt();
    drive(1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b1101_0101) begin failures++; $display("FAIL lu_stall got=%b exp=%b", out_f, 8'b1101_0101); end
    nxt();
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b0000_1010) begin failures++; $display("FAIL lu_after got=%b exp=%b", out_f, 8'b0000_1010); end
    nxt();
  endtask

  task automatic test_x0_and_re();
    do_reset();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 2'b10, 0);
    nxt();
    drive(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b0000_0000) begin failures++; $display("FAIL x0_reader got=%b exp=%b", out_f, 8'b0); end
    checks++; if (out_n !== 8'b0000_0000) begin failures++; $display("FAIL x0_nofwd got=%b exp=%b", out_n, 8'b0); end
    nxt();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 2'b00, 0);
    nxt();
    drive(1, 5'd3, 5'd5, 1, 0, 5'd6, 1, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b0000_0000) begin failures++; $display("FAIL rs2_not_read got=%b exp=%b", out_f, 8'b0); end
    nxt();
  endtask

  task automatic test_branch();
    do_reset();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 2'b00, 1);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b1010_0000) begin failures++; $display("FAIL br_issue got=%b exp=%b", out_f, 8'b1010_0000); end
    checks++; if (out_n !== 8'b1010_0000) begin failures++; $display("FAIL br_issue_nofwd got=%b exp=%b", out_n, 8'b1010_0000); end
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b1010_0000) begin failures++; $display("FAIL br_hold2 got=%b exp=%b", out_f, 8'b1010_0000); end
    nxt();
    for (int i = 0; i < 2; i++) begin
      @(negedge cpu_clk);
      checks++; if (out_f !== 8'b0000_0000) begin failures++; $display("FAIL br_release%0d got=%b exp=%b", i, out_f, 8'b0); end
      nxt();
    end
  endtask

  task automatic test_load_branch();
    do_reset();
    drive(1, 5'd2, 5'd0, 1, 0, 5'd9, 1, 2'b10, 0);
    nxt();
    drive(1, 5'd9, 5'd0, 1, 1, 5'd0, 0, 2'b00, 1);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b1101_0100) begin failures++; $display("FAIL lb_stall got=%b exp=%b", out_f, 8'b1101_0100); end
    nxt();
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b1010_1000) begin failures++; $display("FAIL lb_issue got=%b exp=%b", out_f, 8'b1010_1000); end
    nxt();
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b1010_0000) begin failures++; $display("FAIL lb_hold2 got=%b exp=%b", out_f, 8'b1010_0000); end
    nxt();
    @(negedge cpu_clk);
    checks++; if (out_f !== 8'b0000_0000) begin failures++; $display("FAIL lb_release got=%b exp=%b", out_f, 8'b0); end
    nxt();
  endtask

  task automatic test_nofwd();
    do_reset();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 2'b00, 0);
    nxt();
    drive(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      checks++; if (out_n !== 8'b1101_0000) begin failures++; $display("FAIL nf_stall%0d got=%b exp=%b", i, out_n, 8'b1101_0000); end
      nxt();
    end
    @(negedge cpu_clk);
    checks++; if (out_n !== 8'b0000_0000) begin failures++; $display("FAIL nf_issue got=%b exp=%b", out_n, 8'b0); end
    nxt();
    drive(1, 5'd4, 5'd0, 1, 0, 5'd5, 1, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_n !== 8'b1101_0000) begin failures++; $display("FAIL nf_sub_in_ex got=%b exp=%b", out_n, 8'b1101_0000); end
    nxt();

    do_reset();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 2'b00, 0);
    nxt();
    drive(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 2'b00, 0);
    @(negedge cpu_clk);
    checks++; if (out_n !== 8'b1101_0000) begin failures++; $display("FAIL nfr_stall1 got=%b exp=%b", out_n, 8'b1101_0000); end
    nxt();
    cpu_rst = 1'b1;
    @(negedge cpu_clk);
    checks++; if (out_n !== 8'b0000_0000) begin failures++; $display("FAIL nfr_rst got=%b exp=%b", out_n, 8'b0); end
    nxt();
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    checks++; if (out_n !== 8'b0000_0000) begin failures++; $display("FAIL nfr_empty got=%b exp=%b", out_n, 8'b0); end
    nxt();
  endtask

  initial begin
    cpu_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    nxt();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0_and_re();
    test_branch();
    test_load_branch();
    test_nofwd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
